// File: rtl/alarm_ring_ctrl_pkg.sv
// Shared definitions for the ring alarm overlay.
// Holds the visible-area limits, ring box geometry, ring colours and FSM state codes.
// Used by alarm_ring_ctrl and its frame tick sub-module. The optional build macro
// RING_COLOR_ALT_EN lives in alarm_ring_ctrl.sv.
package alarm_ring_ctrl_pkg;

  typedef logic [11:0] rgb_t;
  typedef logic [1:0]  ring_state_t;

  // Visible raster size
  localparam int unsigned H_VISIBLE = 640;
  localparam int unsigned V_VISIBLE = 480;

  // Ring box, inclusive corners (40x40)
  localparam logic [9:0] RING_X0 = 10'd550;
  localparam logic [9:0] RING_X1 = 10'd589;
  localparam logic [9:0] RING_Y0 = 10'd80;
  localparam logic [9:0] RING_Y1 = 10'd119;

  // Ring colours, 4 bits per channel
  localparam rgb_t RING_RED = 12'hF00;
  localparam rgb_t RING_YEL = 12'hFF0;

  // FSM state codes; code 3 is unused and falls back to idle
  localparam ring_state_t StIdle    = 2'd0;
  localparam ring_state_t StRinging = 2'd1;
  localparam ring_state_t StHold    = 2'd2;

  // Pixel lies inside the ring box; for the figure generator
  function automatic logic in_ring_box(input logic [9:0] x, input logic [9:0] y);
    return (x >= RING_X0) && (x <= RING_X1) && (y >= RING_Y0) && (y <= RING_Y1);
  endfunction

endpackage

// File: rtl/alarm_ring_ctrl_if.sv
// Signal bundle between the VGA/timer side and the ring alarm controller.
// master: drives pixel timing, timer level and ack; slave: the controller.
interface alarm_ring_ctrl_if;

  logic        pixel_tick;
  logic [9:0]  pixel_x;
  logic [9:0]  pixel_y;
  logic        timer_done;
  logic        ring_ack;
  logic        ring_on;
  logic [11:0] ring_RGB;
  logic        alarm_active;

  modport master (
    output pixel_tick,
    output pixel_x,
    output pixel_y,
    output timer_done,
    output ring_ack,
    input  ring_on,
    input  ring_RGB,
    input  alarm_active
  );

  modport slave (
    input  pixel_tick,
    input  pixel_x,
    input  pixel_y,
    input  timer_done,
    input  ring_ack,
    output ring_on,
    output ring_RGB,
    output alarm_active
  );

endinterface

// File: rtl/alarm_ring_ctrl_frame_tick_gen.sv
// End-of-frame strobe: one pixel enable on the last visible pixel.
// Shared by the display overlays so all of them commit changes on the same cycle.
module alarm_ring_ctrl_frame_tick_gen
  import alarm_ring_ctrl_pkg::*;
(
  input  logic       pixel_tick,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       frame_tick
);

  localparam logic [9:0] LastX = 10'(H_VISIBLE - 1);
  localparam logic [9:0] LastY = 10'(V_VISIBLE - 1);

  // Decode the last visible pixel of the frame
  always_comb begin
    frame_tick = pixel_tick && (pixel_x == LastX) && (pixel_y == LastY);
  end

endmodule

// File: rtl/alarm_ring_ctrl.sv
// Ring alarm sequencer for the clock display.
// Latches a timer expiry, blinks the ring box at a frame-locked rate until the
// user acks or a timeout expires, then waits for the timer to clear before
// rearming. Visible outputs only change on the end-of-frame strobe.
// Build option: define RING_COLOR_ALT_EN to keep the box lit for the whole ring
// and alternate red/yellow instead of blinking.
module alarm_ring_ctrl
  import alarm_ring_ctrl_pkg::*;
#(
  parameter int unsigned BLINK_FRAMES   = 30,
  parameter int unsigned TIMEOUT_FRAMES = 1800,
  parameter int unsigned CNT_W          = 11
) (
  input  logic               clk,
  input  logic               reset,
  alarm_ring_ctrl_if.slave   bus
);

  localparam logic [CNT_W-1:0] BlinkLast   = CNT_W'(BLINK_FRAMES - 1);
  localparam logic [CNT_W-1:0] TimeoutLast = CNT_W'(TIMEOUT_FRAMES - 1);

  logic             frame_tick;
  logic             done_q;
  logic             rise;
  ring_state_t      state_q, state_d;
  logic [CNT_W-1:0] blink_cnt_q, blink_cnt_d;
  logic [CNT_W-1:0] to_cnt_q, to_cnt_d;
  logic             phase_q, phase_d;
  logic             ring_on_q, ring_on_d;
  rgb_t             ring_rgb_q, ring_rgb_d;

  alarm_ring_ctrl_frame_tick_gen u_frame_tick_gen (
    .pixel_tick (bus.pixel_tick),
    .pixel_x    (bus.pixel_x),
    .pixel_y    (bus.pixel_y),
    .frame_tick (frame_tick)
  );

  // Timer expiry edge; done_q resets high so a level already high at release is ignored
  always_comb begin
    rise = bus.timer_done & ~done_q;
  end

  // FSM and frame counters next state
  always_comb begin
    state_d     = state_q;
    blink_cnt_d = blink_cnt_q;
    to_cnt_d    = to_cnt_q;
    phase_d     = phase_q;
    case (state_q)
      StIdle: begin
        if (rise) begin
          state_d     = StRinging;
          blink_cnt_d = '0;
          to_cnt_d    = '0;
          phase_d     = 1'b1;
        end
      end
      StRinging: begin
        // Ack beats a coincident frame tick and freezes the counters
        if (bus.ring_ack) begin
          state_d = StHold;
        end else if (frame_tick) begin
          if (to_cnt_q == TimeoutLast) begin
            state_d = StHold;
          end else begin
            to_cnt_d = to_cnt_q + 1'b1;
          end
          if (blink_cnt_q == BlinkLast) begin
            blink_cnt_d = '0;
            phase_d     = ~phase_q;
          end else begin
            blink_cnt_d = blink_cnt_q + 1'b1;
          end
        end
      end
      StHold: begin
        // Timer must go low before another expiry can ring
        if (!bus.timer_done) begin
          state_d = StIdle;
        end
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // Visible outputs, committed only at end of frame to avoid tearing
  always_comb begin
    ring_on_d  = ring_on_q;
    ring_rgb_d = ring_rgb_q;
    if (frame_tick) begin
`ifdef RING_COLOR_ALT_EN
      ring_on_d  = (state_q == StRinging);
      ring_rgb_d = ((state_q == StRinging) && !phase_q) ? RING_YEL : RING_RED;
`else
      ring_on_d  = (state_q == StRinging) & phase_q;
      ring_rgb_d = RING_RED;
`endif
    end
  end

  // State, counters and output registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      done_q      <= 1'b1;
      state_q     <= StIdle;
      blink_cnt_q <= '0;
      to_cnt_q    <= '0;
      phase_q     <= 1'b0;
      ring_on_q   <= 1'b0;
      ring_rgb_q  <= RING_RED;
    end else begin
      done_q      <= bus.timer_done;
      state_q     <= state_d;
      blink_cnt_q <= blink_cnt_d;
      to_cnt_q    <= to_cnt_d;
      phase_q     <= phase_d;
      ring_on_q   <= ring_on_d;
      ring_rgb_q  <= ring_rgb_d;
    end
  end

  // Drive the bus from the registers; alarm_active follows the state register
  always_comb begin
    bus.ring_on      = ring_on_q;
    bus.ring_RGB     = ring_rgb_q;
    bus.alarm_active = (state_q == StRinging);
  end

endmodule

// File: tb/tb_alarm_ring_ctrl.sv
// Bench for alarm_ring_ctrl with a short blink period and timeout and a frame
// tick every 10 clocks. Expected outputs come from a tick-counting model.
module tb_alarm_ring_ctrl;
  import alarm_ring_ctrl_pkg::*;

  localparam int unsigned BLINK   = 2;
  localparam int unsigned TIMEOUT = 8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  alarm_ring_ctrl_if bus ();

  alarm_ring_ctrl #(
    .BLINK_FRAMES   (BLINK),
    .TIMEOUT_FRAMES (TIMEOUT),
    .CNT_W          (11)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int n_checks = 0;
  int n_pass   = 0;
  int n_fail   = 0;
  int cyc      = 0;

  // Model: ringing/holding flags and frame ticks seen since the ring started
  bit          m_ringing;
  bit          m_holding;
  bit          m_td_prev;
  int          m_ticks;
  logic        m_on;
  logic [11:0] m_rgb;

  task automatic check(input string tag, input logic [11:0] got, input logic [11:0] exp);
    n_checks++;
    assert (got === exp) begin
      n_pass++;
    end else begin
      n_fail++;
      $error("FAIL %s got=%h exp=%h cyc=%0d", tag, got, exp, cyc);
    end
  endtask

  task automatic model_reset();
    m_ringing = 1'b0;
    m_holding = 1'b0;
    m_td_prev = 1'b1;
    m_ticks   = 0;
    m_on      = 1'b0;
    m_rgb     = RING_RED;
  endtask

  task automatic check_outputs();
    check("ring_on", 12'(bus.ring_on), 12'(m_on));
    check("alarm_active", 12'(bus.alarm_active), 12'(m_ringing));
    check("ring_RGB", bus.ring_RGB, m_rgb);
  endtask

  // One clock: drive inputs, advance the model, then sample after the edge
  task automatic step(input logic td, input logic ack);
    logic ft;
    logic rise;
    logic was_ringing;
    int   k;
    ft = (cyc % 10 == 9);
    if (ft) begin
      bus.pixel_tick = 1'b1;
      bus.pixel_x    = 10'd639;
      bus.pixel_y    = 10'd479;
    end else begin
      case ($urandom_range(0, 3))
        0: begin bus.pixel_tick = 1'b0; bus.pixel_x = 10'd639; bus.pixel_y = 10'd479; end
        1: begin bus.pixel_tick = 1'b1; bus.pixel_x = 10'd639; bus.pixel_y = 10'd478; end
        2: begin bus.pixel_tick = 1'b1; bus.pixel_x = 10'd638; bus.pixel_y = 10'd479; end
        default: begin
          bus.pixel_tick = 1'($urandom);
          bus.pixel_x    = 10'($urandom_range(0, 637));
          bus.pixel_y    = 10'($urandom_range(0, 524));
        end
      endcase
    end
    bus.timer_done = td;
    bus.ring_ack   = ack;

    rise        = td && !m_td_prev;
    was_ringing = m_ringing;
    k           = m_ticks;
    if (ft) begin
`ifdef RING_COLOR_ALT_EN
      m_on  = was_ringing;
      m_rgb = (was_ringing && ((k / BLINK) % 2 == 1)) ? RING_YEL : RING_RED;
`else
      m_on  = was_ringing && ((k / BLINK) % 2 == 0);
      m_rgb = RING_RED;
`endif
    end
    if (m_ringing) begin
      if (ack) begin
        m_ringing = 1'b0;
        m_holding = 1'b1;
      end else if (ft) begin
        m_ticks++;
        if (m_ticks == TIMEOUT) begin
          m_ringing = 1'b0;
          m_holding = 1'b1;
        end
      end
    end else if (m_holding) begin
      if (!td) m_holding = 1'b0;
    end else if (rise) begin
      m_ringing = 1'b1;
      m_ticks   = 0;
    end
    m_td_prev = td;

    @(posedge clk);
    #1;
    cyc++;
    check_outputs();
  endtask

  initial begin
    reset          = 1'b1;
    bus.pixel_tick = 1'b0;
    bus.pixel_x    = '0;
    bus.pixel_y    = '0;
    bus.timer_done = 1'b1;
    bus.ring_ack   = 1'b0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    check_outputs();

    // Timer already high at reset release must not ring
    repeat (100) step(1'b1, 1'b0);

    // Rise, full blink pattern, timeout into hold, then back to idle
    repeat (5) step(1'b0, 1'b0);
    repeat (100) step(1'b1, 1'b0);
    repeat (5) step(1'b0, 1'b0);

    // Ack coincident with a frame tick; held-high timer keeps it in hold
    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && !(m_ticks == 3 && cyc % 10 == 9); i++) step(1'b1, 1'b0);
    step(1'b1, 1'b1);
    repeat (40) step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);

    // Timer drops mid-ring: still ringing until ack
    step(1'b1, 1'b0);
    repeat (25) step(1'b1, 1'b0);
    repeat (30) step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    repeat (20) step(1'b0, 1'b0);

    // Asynchronous reset while the box is lit
    step(1'b1, 1'b0);
    for (int i = 0; i < 200 && !m_on; i++) step(1'b1, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    model_reset();
    check_outputs();
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    repeat (20) step(1'b1, 1'b0);

    // Random timer levels and ack pulses
    begin
      logic td;
      td = 1'b1;
      for (int i = 0; i < 3000; i++) begin
        if ($urandom_range(0, 59) == 0) td = ~td;
        step(td, ($urandom_range(0, 24) == 0));
      end
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
